// File: rtl/sub_serial_8bit_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package sub_serial_8bit_pkg;
  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/sub_serial_8bit_fs.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/sub_serial_8bit.sv
// Bit-serial subtractor: computes a - b - bin LSB-first, one bit per SHIFT cycle.
module sub_serial_8bit
  import sub_serial_8bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state, next_state;
  logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
  logic [CW-1:0]    cnt;
  logic             br, a_msb, b_msb;
  logic             accept, shift_en;
  logic             bit_d, bit_b;

  fs u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (bit_d),
    .bout (bit_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // SHIFT spends one extra cycle with cnt==WIDTH before DONE, giving WIDTH+1 cycles to done.
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept     = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CW'(WIDTH)) next_state = DONE;
        else                   shift_en   = 1'b1;
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start) begin
          accept     = 1'b1;
          next_state = SHIFT;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      cnt     <= '0;
      br      <= 1'b0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      br    <= bin;
      cnt   <= '0;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (shift_en) begin
      a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
      diff_sr <= {bit_d, diff_sr[WIDTH-1:1]};
      br      <= bit_b;
      cnt     <= cnt + 1'b1;
    end
  end

  assign diff = diff_sr;
  assign bout = br;
  assign ovf  = (a_msb ^ b_msb) & (diff_sr[WIDTH-1] ^ a_msb);
endmodule
